// File: rtl/stream_rescale_pkg.sv
// rtl/stream_rescale_pkg.sv - shared types and helpers for the stream_rescale arbiter
//
// Purpose : arbiter FSM state type, packet counter width and a one-hot to
//           index helper used to select the granted source.
// Ports   : none (package)
package stream_rescale_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    FLUSH = 2'd2
  } arb_state_t;

  localparam int PKT_CNT_W = 16;

  // Widest source count the arbiter supports; onehot2idx works on this width
  // and callers zero-extend their grant vector into it.
  localparam int MAX_SRC = 8;

  // Index of the set bit of a one-hot vector (0 for an all-zero vector).
  function automatic logic [2:0] onehot2idx(input logic [MAX_SRC-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_SRC; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/stream_rescale_arbiter_rr_pick.sv
// rtl/stream_rescale_arbiter_rr_pick.sv - combinational round-robin picker
//
// Purpose : picks the first requester at or after ptr, wrapping cyclically.
// Ports   : req  in  [N_SRC]  request vector
//           ptr  in  [IDX_W]  index with highest priority this round
//           gnt  out [N_SRC]  one-hot pick, 0 when nothing requests
//           any  out 1        at least one request present
module rr_pick
  import stream_rescale_pkg::*;
#(
  parameter int N_SRC = 3,
  parameter int IDX_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_SRC-1:0] gnt,
  output logic             any
);

  logic [IDX_W-1:0] idx;
  logic             found;

  // Walk the sources starting at ptr; the first one requesting wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      idx = IDX_W'((int'(ptr) + i) % N_SRC);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/stream_rescale_arbiter.sv
// rtl/stream_rescale_arbiter.sv - packet round-robin arbiter in front of stream_rescale
//
// Purpose : shares one stream_rescale between N_SRC sources. Grants are held
//           for a whole packet, beats go through one output register, and a
//           stalled packet is closed with a keep=0/last=1 terminator beat.
// Ports   : clk        in   clock, rising edge
//           rst_n      in   asynchronous active-low reset
//           s_data_i   in   per-source lane data [N_SRC][S_KEEP_WIDTH]
//           s_keep_i   in   per-source lane keep
//           s_last_i   in   per-source end of packet
//           s_valid_i  in   per-source beat valid
//           s_ready_o  out  per-source beat accepted
//           m_data_o   out  lane data to stream_rescale
//           m_keep_o   out  lane keep to stream_rescale
//           m_last_o   out  end of packet to stream_rescale
//           m_valid_o  out  beat valid to stream_rescale
//           m_ready_i  in   ready from stream_rescale
//           grant_o    out  one-hot current owner, 0 when idle
//           timeout_o  out  one-cycle pulse on forced termination
//           pkt_cnt_o  out  packets completed, normal and forced
module stream_rescale_arbiter
  import stream_rescale_pkg::*;
#(
  parameter int T_DATA_WIDTH = 4,
  parameter int S_KEEP_WIDTH = 4,
  parameter int N_SRC        = 3,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i  [N_SRC][S_KEEP_WIDTH],
  input  logic [S_KEEP_WIDTH-1:0] s_keep_i  [N_SRC],
  input  logic [N_SRC-1:0]        s_last_i,
  input  logic [N_SRC-1:0]        s_valid_i,
  output logic [N_SRC-1:0]        s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o  [S_KEEP_WIDTH],
  output logic [S_KEEP_WIDTH-1:0] m_keep_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [N_SRC-1:0]        grant_o,
  output logic                    timeout_o,
  output logic [PKT_CNT_W-1:0]    pkt_cnt_o
);

  localparam int IDX_W = $clog2(N_SRC);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] g_idx;
  logic [CNT_W-1:0] idle_cnt;

  logic [N_SRC-1:0] pick_gnt;
  logic             pick_any;

  logic oreg_free;
  logic g_valid;
  logic g_last;
  logic accept;
  logic flush_fire;
  logic pkt_end;
  logic stall_expire;

  rr_pick #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req (s_valid_i),
    .ptr (ptr),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  // grant_o is one-hot outside IDLE, so its index selects the owner's lanes.
  assign g_idx   = IDX_W'(onehot2idx(MAX_SRC'(grant_o)));
  assign g_valid = s_valid_i[g_idx];
  assign g_last  = s_last_i[g_idx];

  // The output register can take a beat when empty or draining this cycle;
  // using m_ready_i directly avoids a bubble between back-to-back beats.
  assign oreg_free = !m_valid_o || m_ready_i;
  assign ptr_nxt   = (g_idx == IDX_W'(N_SRC - 1)) ? '0 : g_idx + 1'b1;

  // The counter reaches TIMEOUT_CYC-1 on the edge where it holds TIMEOUT_CYC-2
  // and the owner is still silent; that edge is the one that enters FLUSH.
  assign stall_expire = (state == GRANT) && !g_valid &&
                        (idle_cnt == CNT_W'(TIMEOUT_CYC - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    s_ready_o  = '0;
    accept     = 1'b0;
    flush_fire = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) state_nxt = GRANT;
      end
      GRANT: begin
        if (oreg_free) s_ready_o = grant_o;
        accept = oreg_free && g_valid;
        if (accept && g_last) state_nxt = IDLE;
        else if (stall_expire) state_nxt = FLUSH;
      end
      FLUSH: begin
        flush_fire = oreg_free;
        if (oreg_free) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pkt_end = (accept && g_last) || flush_fire;

  // Ownership, round-robin pointer, packet counter and stall watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_o   <= '0;
      ptr       <= '0;
      pkt_cnt_o <= '0;
      idle_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= flush_fire;

      if (state == IDLE && pick_any) begin
        grant_o <= pick_gnt;
      end else if (pkt_end) begin
        grant_o   <= '0;
        ptr       <= ptr_nxt;
        pkt_cnt_o <= pkt_cnt_o + PKT_CNT_W'(1);
      end

      // Only owner silence counts; back-pressure with valid high does not.
      if (state == GRANT) begin
        if (accept)        idle_cnt <= '0;
        else if (!g_valid) idle_cnt <= idle_cnt + CNT_W'(1);
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  // Output register. m_* hold while m_valid_o && !m_ready_i because neither
  // accept nor flush_fire can happen without oreg_free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_o  <= '{default: '0};
      m_keep_o  <= '0;
      m_last_o  <= 1'b0;
      m_valid_o <= 1'b0;
    end else if (accept) begin
      m_data_o  <= s_data_i[g_idx];
      m_keep_o  <= s_keep_i[g_idx];
      m_last_o  <= g_last;
      m_valid_o <= 1'b1;
    end else if (flush_fire) begin
      // Empty terminator beat: closes the packet inside stream_rescale.
      m_data_o  <= '{default: '0};
      m_keep_o  <= '0;
      m_last_o  <= 1'b1;
      m_valid_o <= 1'b1;
    end else if (m_ready_i) begin
      m_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_rescale_arbiter.sv
// tb/tb_stream_rescale_arbiter.sv - directed self-checking bench for stream_rescale_arbiter
module tb_stream_rescale_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] s_data [3][4];
  logic [3:0] s_keep [3];
  logic [2:0] s_last = '0;
  logic [2:0] s_valid = '0;
  logic [2:0] s_ready;
  logic [3:0] m_data [4];
  logic [3:0] m_keep;
  logic       m_last;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [2:0] grant;
  logic       timeout;
  logic [15:0] pkt_cnt;

  logic [15:0] mw;
  int total = 0;
  int bad = 0;

  assign mw = {m_data[0], m_data[1], m_data[2], m_data[3]};

  always #5 clk = ~clk;

  stream_rescale_arbiter #(
    .T_DATA_WIDTH (4),
    .S_KEEP_WIDTH (4),
    .N_SRC        (3),
    .TIMEOUT_CYC  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data),
    .s_keep_i  (s_keep),
    .s_last_i  (s_last),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .m_data_o  (m_data),
    .m_keep_o  (m_keep),
    .m_last_o  (m_last),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .grant_o   (grant),
    .timeout_o (timeout),
    .pkt_cnt_o (pkt_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_src(input logic [1:0] k, input logic [15:0] w, input logic [3:0] keep,
                         input logic last, input logic valid);
    s_data[k][0] = w[15:12];
    s_data[k][1] = w[11:8];
    s_data[k][2] = w[7:4];
    s_data[k][3] = w[3:0];
    s_keep[k]    = keep;
    s_last[k]    = last;
    s_valid[k]   = valid;
  endtask

  // Leaves reset released just after an edge with all sources idle.
  task automatic do_reset();
    s_valid = '0;
    s_last  = '0;
    m_ready = 1'b1;
    rst_n   = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic [2:0]  exp_g  [10] = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000, 3'b001};
  logic        exp_mv [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic        exp_ml [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [15:0] exp_w  [10] = '{16'h0, 16'h00A5, 16'h01A5, 16'h0, 16'h10A5, 16'h11A5, 16'h0, 16'h20A5, 16'h21A5, 16'h0};

  initial begin
    logic [2:0] beat;
    logic [2:0] acc;

    for (int k = 0; k < 3; k++) begin
      s_keep[k] = '0;
      for (int l = 0; l < 4; l++) s_data[k][l] = '0;
    end

    // 1: reset held with all sources requesting
    set_src(2'd0, 16'h1234, 4'hF, 1'b0, 1'b1);
    set_src(2'd1, 16'h5678, 4'hF, 1'b0, 1'b1);
    set_src(2'd2, 16'h9ABC, 4'hF, 1'b0, 1'b1);
    step();
    step();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ready", 32'(s_ready), 32'h0);
    chk("rst_mvalid", 32'(m_valid), 32'h0);
    chk("rst_mlast", 32'(m_last), 32'h0);
    chk("rst_mkeep", 32'(m_keep), 32'h0);
    chk("rst_mdata", 32'(mw), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_pkt", 32'(pkt_cnt), 32'h0);
    rst_n = 1'b1;
    step();
    chk("rel_grant", 32'(grant), 32'h1);
    chk("rel_pkt", 32'(pkt_cnt), 32'h0);

    // 2: single 3-beat packet from src0
    do_reset();
    set_src(2'd0, 16'h1234, 4'hF, 1'b0, 1'b1);
    step();
    chk("t2_grant", 32'(grant), 32'h1);
    chk("t2_ready", 32'(s_ready), 32'h1);
    step();
    chk("t2_b1_data", 32'(mw), 32'h1234);
    chk("t2_b1_valid", 32'(m_valid), 32'h1);
    chk("t2_b1_last", 32'(m_last), 32'h0);
    chk("t2_b1_keep", 32'(m_keep), 32'hF);
    set_src(2'd0, 16'h5678, 4'hF, 1'b0, 1'b1);
    step();
    chk("t2_b2_data", 32'(mw), 32'h5678);
    set_src(2'd0, 16'h9ABC, 4'hF, 1'b1, 1'b1);
    step();
    chk("t2_b3_data", 32'(mw), 32'h9ABC);
    chk("t2_b3_last", 32'(m_last), 32'h1);
    chk("t2_grant_end", 32'(grant), 32'h0);
    chk("t2_pkt", 32'(pkt_cnt), 32'h1);
    set_src(2'd0, 16'h0, 4'h0, 1'b0, 1'b0);
    step();
    chk("t2_drain", 32'(m_valid), 32'h0);

    // 3: three sources with continuous 2-beat packets
    do_reset();
    beat = '0;
    for (int i = 0; i < 10; i++) begin
      set_src(2'd0, {4'h0, 3'b0, beat[0], 8'hA5}, 4'hF, beat[0], 1'b1);
      set_src(2'd1, {4'h1, 3'b0, beat[1], 8'hA5}, 4'hF, beat[1], 1'b1);
      set_src(2'd2, {4'h2, 3'b0, beat[2], 8'hA5}, 4'hF, beat[2], 1'b1);
      #1;
      acc = s_valid & s_ready;
      step();
      beat = beat ^ acc;
      chk($sformatf("t3_grant_%0d", i), 32'(grant), 32'(exp_g[i]));
      chk($sformatf("t3_mvalid_%0d", i), 32'(m_valid), 32'(exp_mv[i]));
      if (exp_mv[i]) begin
        chk($sformatf("t3_mdata_%0d", i), 32'(mw), 32'(exp_w[i]));
        chk($sformatf("t3_mlast_%0d", i), 32'(m_last), 32'(exp_ml[i]));
      end
    end
    chk("t3_pkt", 32'(pkt_cnt), 32'h3);

    // 4: back-pressure after the first beat of a src1 packet
    do_reset();
    set_src(2'd1, 16'h1111, 4'hF, 1'b0, 1'b1);
    step();
    chk("t4_grant", 32'(grant), 32'h2);
    step();
    chk("t4_b1_data", 32'(mw), 32'h1111);
    m_ready = 1'b0;
    set_src(2'd1, 16'h2222, 4'hF, 1'b0, 1'b1);
    #1;
    chk("t4_ready_stall", 32'(s_ready), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t4_frozen_data_%0d", i), 32'(mw), 32'h1111);
      chk($sformatf("t4_frozen_valid_%0d", i), 32'(m_valid), 32'h1);
      chk($sformatf("t4_ready_%0d", i), 32'(s_ready), 32'h0);
    end
    m_ready = 1'b1;
    #1;
    chk("t4_ready_resume", 32'(s_ready), 32'h2);
    step();
    chk("t4_b2_data", 32'(mw), 32'h2222);
    set_src(2'd1, 16'h3333, 4'hF, 1'b1, 1'b1);
    step();
    chk("t4_b3_data", 32'(mw), 32'h3333);
    chk("t4_b3_last", 32'(m_last), 32'h1);
    chk("t4_grant_end", 32'(grant), 32'h0);
    chk("t4_pkt", 32'(pkt_cnt), 32'h1);
    chk("t4_no_timeout", 32'(timeout), 32'h0);

    // 5: src1 stalls mid-packet, watchdog closes it
    do_reset();
    set_src(2'd1, 16'h4444, 4'hF, 1'b0, 1'b1);
    step();
    chk("t5_grant", 32'(grant), 32'h2);
    step();
    chk("t5_b1_data", 32'(mw), 32'h4444);
    set_src(2'd1, 16'h0, 4'h0, 1'b0, 1'b0);
    set_src(2'd0, 16'h5555, 4'hF, 1'b1, 1'b1);
    set_src(2'd2, 16'h7777, 4'hF, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("t5_hold_grant_%0d", i), 32'(grant), 32'h2);
      chk($sformatf("t5_hold_timeout_%0d", i), 32'(timeout), 32'h0);
      chk($sformatf("t5_hold_mvalid_%0d", i), 32'(m_valid), 32'h0);
      chk($sformatf("t5_hold_ready_%0d", i), 32'(s_ready), 32'h2);
    end
    step();
    chk("t5_flush_ready", 32'(s_ready), 32'h0);
    chk("t5_flush_timeout", 32'(timeout), 32'h0);
    chk("t5_flush_mvalid", 32'(m_valid), 32'h0);
    step();
    chk("t5_term_valid", 32'(m_valid), 32'h1);
    chk("t5_term_keep", 32'(m_keep), 32'h0);
    chk("t5_term_last", 32'(m_last), 32'h1);
    chk("t5_term_data", 32'(mw), 32'h0);
    chk("t5_timeout", 32'(timeout), 32'h1);
    chk("t5_grant_end", 32'(grant), 32'h0);
    chk("t5_pkt", 32'(pkt_cnt), 32'h1);
    step();
    chk("t5_timeout_pulse", 32'(timeout), 32'h0);
    chk("t5_next_grant", 32'(grant), 32'h4);
    chk("t5_idle_mvalid", 32'(m_valid), 32'h0);
    step();
    chk("t5_src2_data", 32'(mw), 32'h7777);
    chk("t5_src2_last", 32'(m_last), 32'h1);
    chk("t5_pkt2", 32'(pkt_cnt), 32'h2);

    // 6: asynchronous reset between edges mid-packet
    do_reset();
    set_src(2'd2, 16'hAAAA, 4'hF, 1'b0, 1'b1);
    step();
    chk("t6_grant", 32'(grant), 32'h4);
    step();
    chk("t6_mvalid", 32'(m_valid), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_mvalid", 32'(m_valid), 32'h0);
    chk("t6_async_grant", 32'(grant), 32'h0);
    set_src(2'd0, 16'hBBBB, 4'hF, 1'b1, 1'b1);
    set_src(2'd1, 16'hCCCC, 4'hF, 1'b1, 1'b1);
    #1;
    rst_n = 1'b1;
    step();
    chk("t6_regrant", 32'(grant), 32'h1);
    chk("t6_pkt", 32'(pkt_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
